hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 21 ++
 rtl/hazard_scoreboard_sb_counter.sv | 57 +++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared pipeline constants for the register hazard scoreboard:
//               number of tracked registers, in-flight counter width,
//               register index width and the untracked PC index.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Tracked general registers R0..R14.
    localparam int NUM_REGS  = 15;
    // Width of each per-register in-flight writer counter.
    localparam int CNT_W     = 2;
    // Width of a register index on the decode/writeback buses.
    localparam int REG_IDX_W = 4;
    // Index 15 is the PC; it is never tracked.
    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : One saturating up/down in-flight writer counter.
//               Simultaneous inc and dec cancel. Incrementing at the maximum
//               holds the value and pulses o_ovf; decrementing at zero holds
//               the value and pulses o_unf. Pulses are combinational and
//               describe the update taken at the next rising edge.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-low reset
//               i_inc  - add one writer at the next edge
//               i_dec  - remove one writer at the next edge
//               o_cnt  - current count (registered)
//               o_ovf  - this cycle's increment would overflow
//               o_unf  - this cycle's decrement would underflow
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf,
    output logic             o_unf
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_max;
    logic             w_zero;
    logic             w_up;
    logic             w_down;

    assign w_max  = &r_cnt;
    assign w_zero = (r_cnt == '0);
    // Only one-sided requests move the counter.
    assign w_up   = i_inc & ~i_dec;
    assign w_down = i_dec & ~i_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_up && !w_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_down && !w_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = w_up & w_max;
    assign o_unf = w_down & w_zero;

endmodule : sb_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Read-after-write hazard scoreboard for R0..R14. Keeps one
//               saturating in-flight writer counter per register, raises a
//               combinational decode stall when a used source has an
//               outstanding writer, and records sticky overflow/underflow.
// Ports       : clk, rst               - clock, async active-low reset
//               issue_valid/_wb_en     - decode presents a writing instruction
//               issue_dest             - its destination register
//               src1/src2, srcN_used   - decode source registers
//               flush                  - squash the presented instruction
//               retire_en/retire_dest  - writeback commit (RF write port)
//               hazard                 - stall decode this cycle
//               pending                - per-register nonzero counter flags
//               ovf_err / unf_err      - sticky counter error flags
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = hazard_scoreboard_pkg::NUM_REGS,
    parameter int CNT_W    = hazard_scoreboard_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 issue_wb_en,
    input  logic [3:0]           issue_dest,
    input  logic                 src1_used,
    input  logic                 src2_used,
    input  logic [3:0]           src1,
    input  logic [3:0]           src2,
    input  logic                 flush,
    input  logic                 retire_en,
    input  logic [3:0]           retire_dest,
    output logic                 hazard,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 ovf_err,
    output logic                 unf_err
);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_ovf;
    logic [NUM_REGS-1:0] w_unf;
    logic [NUM_REGS-1:0] w_busy;
    logic                w_busy1;
    logic                w_busy2;
    logic                w_issue_fire;
    logic                r_ovf_err;
    logic                r_unf_err;

    // A hazard blocks its own instruction's issue, so the stall feeds the
    // issue qualifier combinationally.
    assign w_issue_fire = issue_valid & issue_wb_en & ~hazard & ~flush;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            localparam logic [3:0] c_idx = 4'(i);
            logic w_retire_here;

            assign w_retire_here = retire_en & (retire_dest == c_idx);
            assign w_inc[i]      = w_issue_fire & (issue_dest == c_idx);
            assign w_dec[i]      = w_retire_here;

            // The register file writes on the falling edge, so a single
            // outstanding writer that retires this cycle is already readable.
            assign w_busy[i] = (w_cnt[i] > CNT_W'(1)) |
                               ((w_cnt[i] == CNT_W'(1)) & ~w_retire_here);

            assign pending[i] = |w_cnt[i];

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .i_inc (w_inc[i]),
                .i_dec (w_dec[i]),
                .o_cnt (w_cnt[i]),
                .o_ovf (w_ovf[i]),
                .o_unf (w_unf[i])
            );
        end
    endgenerate

    // Source lookup; indices outside R0..R14 (the PC) never match a counter.
    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src1 == 4'(i)) w_busy1 = w_busy[i];
            if (src2 == 4'(i)) w_busy2 = w_busy[i];
        end
        if (src1 == PC_IDX) w_busy1 = 1'b0;
        if (src2 == PC_IDX) w_busy2 = 1'b0;
    end

    assign hazard = (src1_used & w_busy1) | (src2_used & w_busy2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (|w_ovf) r_ovf_err <= 1'b1;
            if (|w_unf) r_unf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;
    assign unf_err = r_unf_err;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. A table of
//               per-cycle vectors carries hand-derived expected hazard and
//               post-edge state; the post-edge expectation is queued when the
//               vector is driven and popped after the rising edge. A short
//               hand-written sequence covers asynchronous reset mid-run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic        src1_used;
    logic        src2_used;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        flush;
    logic        retire_en;
    logic [3:0]  retire_dest;
    logic        hazard;
    logic [14:0] pending;
    logic        ovf_err;
    logic        unf_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic        wb;
        logic [3:0]  d;
        logic        s1u;
        logic [3:0]  s1;
        logic        s2u;
        logic [3:0]  s2;
        logic        fl;
        logic        ret;
        logic [3:0]  rd;
        logic        h;
        logic [14:0] p;
        logic        o;
        logic        u;
    } vec_t;

    typedef struct packed {
        logic [14:0] p;
        logic        o;
        logic        u;
    } post_t;

    vec_t  vecs [$];
    post_t sb_q [$];

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wb_en (issue_wb_en),
        .issue_dest  (issue_dest),
        .src1_used   (src1_used),
        .src2_used   (src2_used),
        .src1        (src1),
        .src2        (src2),
        .flush       (flush),
        .retire_en   (retire_en),
        .retire_dest (retire_dest),
        .hazard      (hazard),
        .pending     (pending),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit v, bit wb, int d, bit s1u, int s1, bit s2u,
                                int s2, bit fl, bit ret, int rd, bit h, int p,
                                bit o, bit u);
        vec_t t;
        t.v = v;  t.wb = wb;  t.d = 4'(d);
        t.s1u = s1u;  t.s1 = 4'(s1);  t.s2u = s2u;  t.s2 = 4'(s2);
        t.fl = fl;  t.ret = ret;  t.rd = 4'(rd);
        t.h = h;  t.p = 15'(p);  t.o = o;  t.u = u;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
        src1_used = 0; src2_used = 0; src1 = 0; src2 = 0;
        flush = 0; retire_en = 0; retire_dest = 0;
    endtask

    // Called at posedge+1; drives one cycle and checks both the
    // combinational stall and the state after the following edge.
    task automatic apply(input vec_t t, input int idx);
        post_t e;
        issue_valid = t.v;  issue_wb_en = t.wb;  issue_dest = t.d;
        src1_used = t.s1u;  src1 = t.s1;  src2_used = t.s2u;  src2 = t.s2;
        flush = t.fl;  retire_en = t.ret;  retire_dest = t.rd;
        #2;
        chk($sformatf("v%0d hazard", idx), 32'(hazard), 32'(t.h));
        sb_q.push_back('{p: t.p, o: t.o, u: t.u});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk($sformatf("v%0d queue", idx), 32'(0), 32'(1));
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d pending", idx), 32'(pending), 32'(e.p));
            chk($sformatf("v%0d ovf_err", idx), 32'(ovf_err), 32'(e.o));
            chk($sformatf("v%0d unf_err", idx), 32'(unf_err), 32'(e.u));
        end
    endtask

    initial begin
        //         v wb d  s1u s1 s2u s2 fl ret rd  h  pend    o  u
        vecs.push_back(mk(1,1,3,  0,0,  0,0,  0, 0,0,  0,'h0008,0,0)); // issue R3
        vecs.push_back(mk(0,0,0,  1,3,  0,0,  0, 0,0,  1,'h0008,0,0)); // stall 1
        vecs.push_back(mk(1,1,9,  1,3,  0,0,  0, 0,0,  1,'h0008,0,0)); // stall 2, R9 blocked
        vecs.push_back(mk(0,0,0,  1,3,  0,0,  0, 1,3,  0,'h0000,0,0)); // retire bypass
        vecs.push_back(mk(1,1,2,  0,0,  0,0,  0, 0,0,  0,'h0004,0,0)); // issue R2
        vecs.push_back(mk(1,1,2,  0,0,  0,0,  0, 1,2,  0,'h0004,0,0)); // issue+retire R2
        vecs.push_back(mk(0,0,0,  0,0,  1,2,  0, 1,2,  0,'h0000,0,0)); // src2 bypass
        vecs.push_back(mk(1,1,4,  0,0,  0,0,  1, 0,0,  0,'h0000,0,0)); // flushed R4
        vecs.push_back(mk(1,1,15, 0,0,  0,0,  0, 0,0,  0,'h0000,0,0)); // issue PC
        vecs.push_back(mk(0,0,0,  1,15, 1,15, 0, 1,15, 0,'h0000,0,0)); // src/retire PC
        vecs.push_back(mk(1,1,6,  1,6,  0,0,  0, 0,0,  0,'h0040,0,0)); // issue R6
        vecs.push_back(mk(1,1,1,  1,6,  0,0,  0, 0,0,  1,'h0040,0,0)); // stalled R1
        vecs.push_back(mk(1,1,1,  1,6,  0,0,  0, 1,6,  0,'h0002,0,0)); // bypass lets R1 go
        vecs.push_back(mk(1,0,8,  0,0,  0,0,  0, 1,1,  0,'h0000,0,0)); // no wb_en
        vecs.push_back(mk(1,1,5,  0,0,  0,0,  0, 0,0,  0,'h0020,0,0)); // R5 = 1
        vecs.push_back(mk(1,1,5,  0,0,  0,0,  0, 0,0,  0,'h0020,0,0)); // R5 = 2
        vecs.push_back(mk(1,1,5,  0,0,  0,0,  0, 0,0,  0,'h0020,0,0)); // R5 = 3
        vecs.push_back(mk(1,1,5,  0,0,  0,0,  0, 0,0,  0,'h0020,1,0)); // overflow
        vecs.push_back(mk(0,0,0,  0,0,  1,5,  0, 0,0,  1,'h0020,1,0)); // sticky, cnt 3
        vecs.push_back(mk(0,0,0,  0,0,  0,0,  0, 1,7,  0,'h0020,1,1)); // underflow R7
        vecs.push_back(mk(0,0,0,  1,5,  0,0,  0, 1,5,  1,'h0020,1,1)); // 3 -> 2
        vecs.push_back(mk(0,0,0,  1,5,  0,0,  0, 1,5,  1,'h0020,1,1)); // 2 -> 1
        vecs.push_back(mk(0,0,0,  1,5,  0,0,  0, 1,5,  0,'h0000,1,1)); // 1 -> 0
        vecs.push_back(mk(1,1,1,  0,0,  0,0,  0, 0,0,  0,'h0002,1,1)); // R1 = 1
        vecs.push_back(mk(1,1,1,  0,0,  0,0,  0, 0,0,  0,'h0002,1,1)); // R1 = 2

        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hazard",  32'(hazard),  32'(0));
        chk("reset pending", 32'(pending), 32'(0));
        chk("reset ovf_err", 32'(ovf_err), 32'(0));
        chk("reset unf_err", 32'(unf_err), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Mid-run asynchronous reset with cnt[1] = 2 and both flags set.
        idle();
        src1_used = 1; src1 = 4'd1;
        #2;
        chk("pre-rst hazard R1", 32'(hazard), 32'(1));
        rst = 1'b0;
        #1;
        chk("async rst hazard",  32'(hazard),  32'(0));
        chk("async rst pending", 32'(pending), 32'(0));
        chk("async rst ovf_err", 32'(ovf_err), 32'(0));
        chk("async rst unf_err", 32'(unf_err), 32'(0));
        issue_valid = 1; issue_wb_en = 1; issue_dest = 4'd3;
        src1_used = 0;
        @(posedge clk);
        #1;
        chk("held rst pending", 32'(pending), 32'(0));
        #5;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst pending", 32'(pending), 32'(0));
        apply(mk(1,1,1, 0,0, 0,0, 0, 0,0, 0,'h0002,0,0), 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
